// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops,
// iterative one-bit-per-cycle shifts, valid/ready on both sides.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic                  illegal_op
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_AND = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_SLT = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_SLL = 4'b0110;
  localparam logic [OP_WIDTH-1:0] OP_SRL = 4'b0111;
  localparam logic [OP_WIDTH-1:0] OP_BEQ = 4'b1000;
  localparam logic [OP_WIDTH-1:0] OP_SRA = 4'b1001;
  localparam logic [OP_WIDTH-1:0] OP_BNE = 4'b1010;

  localparam logic [SW-1:0] CNT_ONE = 1;
  localparam logic [DATA_WIDTH-1:0] D_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] D_ONE  = 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [SW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] comb_res;
  logic                  comb_ill;
  logic                  is_shift;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] acc_nxt;

  assign shamt = src_b[SW-1:0];

  // Single-cycle result; shift ops pass src_a through (shamt==0 case).
  always_comb begin
    comb_res = D_ZERO;
    comb_ill = 1'b0;
    is_shift = 1'b0;
    case (operation)
      OP_AND: comb_res = src_a & src_b;
      OP_OR:  comb_res = src_a | src_b;
      OP_ADD: comb_res = src_a + src_b;
      OP_XOR: comb_res = src_a ^ src_b;
      OP_SUB: comb_res = src_a - src_b;
      OP_SLT: comb_res = ($signed(src_a) < $signed(src_b)) ? D_ONE : D_ZERO;
      OP_BEQ: comb_res = (src_a == src_b) ? D_ONE : D_ZERO;
      OP_BNE: comb_res = (src_a != src_b) ? D_ONE : D_ZERO;
      OP_SLL, OP_SRL, OP_SRA: begin
        comb_res = src_a;
        is_shift = 1'b1;
      end
      default: comb_ill = 1'b1;
    endcase
  end

  // One-bit step of the captured shift op.
  always_comb begin
    acc_nxt = acc;
    case (op_q)
      OP_SLL:  acc_nxt = {acc[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  acc_nxt = {1'b0, acc[DATA_WIDTH-1:1]};
      OP_SRA:  acc_nxt = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
      default: acc_nxt = acc;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      alu_result <= D_ZERO;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
      op_q       <= '0;
      acc        <= D_ZERO;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift && shamt != '0) begin
              op_q  <= operation;
              acc   <= src_a;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              alu_result <= comb_res;
              zero       <= (comb_res == D_ZERO);
              illegal_op <= comb_ill;
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            alu_result <= acc_nxt;
            zero       <= (acc_nxt == D_ZERO);
            illegal_op <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus
// randomized ops against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

  function automatic bit is_shift_op(input logic [3:0] op);
    return op == 4'd6 || op == 4'd7 || op == 4'd9;
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a - b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return $unsigned($signed(a) >>> sh);
      4'd10: return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op,
                                 input logic [31:0] b);
    if (is_shift_op(op)) return int'(b % 32) + 1;
    return 1;
  endfunction

  task automatic accept(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 4'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int bp);
    logic [31:0] exp;
    int lat;
    exp = ref_res(op, a, b);
    accept(op, a, b);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(op, b)));
    check({tag, "_res"}, alu_result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    check({tag, "_ill"}, 32'(illegal_op), 32'(!is_legal(op)));
    for (int i = 0; i < bp; i++) begin
      in_valid  = 1'($urandom);
      operation = 4'd2;
      @(negedge clk);
      check({tag, "_bp_res"}, alu_result, exp);
      check({tag, "_bp_ov"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_ir"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ir"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operation = 4'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    #12;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_res", alu_result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ill", 32'(illegal_op), 32'd0);
    check("rst_ir", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    do_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sub", 4'd4, 32'd5, 32'd7, 0);
    do_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("slt_pos", 4'd5, 32'd1, 32'hFFFF_FFFF, 0);
    do_op("beq", 4'd8, 32'd3, 32'd3, 0);
    do_op("bne", 4'd10, 32'd3, 32'd3, 0);
    do_op("sra4", 4'd9, 32'h8000_0000, 32'd4, 0);
    do_op("srl4", 4'd7, 32'h8000_0000, 32'd4, 0);
    do_op("sll31", 4'd6, 32'd1, 32'd31, 0);
    do_op("sll_sh0", 4'd6, 32'h1234_5678, 32'h20, 0);
    do_op("sra_sh0", 4'd9, 32'h8765_4321, 32'h40, 0);
    do_op("illegal", 4'hF, 32'h55, 32'h66, 0);
    do_op("backpr", 4'd3, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 10);

    accept(4'd6, 32'h0000_0001, 32'd20);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_ov", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_abort", 32'(seen), 32'd0);
    check("rst_abort_ir", 32'(in_ready), 32'd1);
    do_op("add_after", 4'd2, 32'd2, 32'd2, 0);

    for (int k = 0; k < 60; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
